pipe_stage_hs: RTL

- Generic, parametrised pipeline-stage register for the RISC-V core. It replaces hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with a single block.
- Uses a valid/ready handshake, an optional skid slot for full-throughput backpressure, and synchronous flush that inserts bubbles.
- Output is split into a control field, which is forced to zero (NOP) on a bubble, and a data payload, which is zeroed only on request.

---
 rtl/pipe_pkg.sv | 47 ++++
 rtl/pipe_slot.sv | 68 ++++++
 rtl/pipe_stage_hs.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Purpose : Shared constants for the RISC-V pipeline-stage registers.
//           Per-stage control/payload widths and the bit layout of the
//           ID/EX control bundle, so every stage packs and unpacks alike.
// Ports   : none (package).
package pipe_pkg;

    // IF/ID carries no decoded control yet; one bit is reserved so the
    // control field never has zero width.
    localparam int unsigned IFID_CTRL_W  = 1;
    localparam int unsigned IFID_DATA_W  = 96;   // Instr, PC, PCPlus4
    localparam int unsigned IDEX_CTRL_W  = 10;
    localparam int unsigned IDEX_DATA_W  = 175;  // RD1, RD2, PC, ImmExt, PCPlus4, Rd, Rs1, Rs2
    localparam int unsigned EXMEM_CTRL_W = 4;    // RegWrite, MemWrite, ResultSrc[1:0]
    localparam int unsigned EXMEM_DATA_W = 101;  // ALUResult, WriteData, PCPlus4, Rd
    localparam int unsigned MEMWB_CTRL_W = 3;    // RegWrite, ResultSrc[1:0]
    localparam int unsigned MEMWB_DATA_W = 101;  // ALUResult, ReadData, PCPlus4, Rd

    // ID/EX control-bundle field offsets.
    localparam int unsigned CTRL_REG_WRITE      = 0;
    localparam int unsigned CTRL_MEM_WRITE      = 1;
    localparam int unsigned CTRL_JUMP           = 2;
    localparam int unsigned CTRL_BRANCH         = 3;
    localparam int unsigned CTRL_ALU_SRC        = 4;
    localparam int unsigned CTRL_RESULT_SRC_LSB = 5;
    localparam int unsigned CTRL_RESULT_SRC_MSB = 6;
    localparam int unsigned CTRL_ALU_CTRL_LSB   = 7;
    localparam int unsigned CTRL_ALU_CTRL_MSB   = 9;

    // Same layout as a packed struct (first member is the MSB end).
    typedef struct packed {
        logic [2:0] alu_control;
        logic [1:0] result_src;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       mem_write;
        logic       reg_write;
    } idex_ctrl_t;

    // Occupancy of a stage, decoded from the slot valid bits.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_slot.sv
// Purpose : One pipeline entry: valid + control + payload registers.
// Ports   : clk, reset  - clock, async active-high reset
//           i_clear     - synchronous kill: valid and ctrl (and data if ZERO_DATA) cleared
//           i_load      - capture i_ctrl/i_data and mark the entry valid
//           i_drop      - entry consumed: valid cleared, registers kept
//           i_ctrl/data - values to capture
//           o_valid/o_ctrl/o_data - held entry
module pipe_slot #(
    parameter int unsigned CTRL_W    = 10,
    parameter int unsigned DATA_W    = 175,
    parameter bit          ZERO_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_drop,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Clear has priority over load and drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
        end else if (i_drop) begin
            r_valid <= 1'b0;
        end
    end

    if (ZERO_DATA) begin : g_data_zero
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_data <= '0;
            end else if (i_clear) begin
                r_data <= '0;
            end else if (i_load) begin
                r_data <= i_data;
            end
        end
    end else begin : g_data_keep
        // No reset or clear: payload is don't-care while invalid.
        always_ff @(posedge clk) begin
            if (i_load && !i_clear) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_hs.sv
// Purpose : Generic valid/ready pipeline-stage register with optional skid
//           slot, synchronous flush and NOP-gated control output.
// Ports   : clk, reset            - clock, async active-high reset
//           flush                 - synchronous kill of all held entries
//           in_valid/in_ready     - upstream handshake
//           in_ctrl/in_data       - upstream control bundle / payload
//           out_valid/out_ready   - downstream handshake
//           out_ctrl/out_data     - control (zero on bubble) / payload
//           occupancy             - number of held entries (0..2)
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W    = IDEX_CTRL_W,
    parameter int unsigned DATA_W    = IDEX_DATA_W,
    parameter bit          SKID_EN   = 1'b1,
    parameter bit          ZERO_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              w_main_valid, w_skid_valid;
    logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_in_ctrl;
    logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_in_data;
    logic              w_accept, w_fire;
    logic              w_main_load, w_main_drop, w_main_src_skid;
    logic              w_skid_load, w_skid_drop;
    stage_state_e      w_state;

    assign w_accept = in_valid && in_ready;
    assign w_fire   = out_valid && out_ready;

    // State is held in the slot valid bits; decode it here.
    always_comb begin
        w_state = StEmpty;
        if (w_skid_valid) begin
            w_state = StTwo;
        end else if (w_main_valid) begin
            w_state = StOne;
        end
    end

    // Next-state steering. Flush overrides everything via the slot clears.
    always_comb begin
        w_main_load     = 1'b0;
        w_main_drop     = 1'b0;
        w_main_src_skid = 1'b0;
        w_skid_load     = 1'b0;
        w_skid_drop     = 1'b0;
        if (!flush) begin
            case (w_state)
                StEmpty: w_main_load = w_accept;
                StOne: begin
                    if (w_fire) begin
                        w_main_load = w_accept;
                        w_main_drop = !w_accept;
                    end else begin
                        // Only reachable with SKID_EN: single-entry in_ready is 0 here.
                        w_skid_load = w_accept;
                    end
                end
                StTwo: begin
                    // Skid entry is older than anything upstream.
                    if (w_fire) begin
                        w_main_load     = 1'b1;
                        w_main_src_skid = 1'b1;
                        w_skid_drop     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        if (SKID_EN) begin
            in_ready = !w_skid_valid;
        end else begin
            in_ready = !w_main_valid || out_ready;
        end
        out_valid = w_main_valid;
        out_ctrl  = w_main_valid ? w_main_ctrl : '0;
        out_data  = w_main_data;
        occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
    end

    assign w_main_in_ctrl = w_main_src_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_in_data = w_main_src_skid ? w_skid_data : in_data;

    pipe_slot #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .ZERO_DATA (ZERO_DATA)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_load  (w_main_load),
        .i_drop  (w_main_drop),
        .i_ctrl  (w_main_in_ctrl),
        .i_data  (w_main_in_data),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    if (SKID_EN) begin : g_skid
        pipe_slot #(
            .CTRL_W    (CTRL_W),
            .DATA_W    (DATA_W),
            .ZERO_DATA (ZERO_DATA)
        ) u_skid (
            .clk     (clk),
            .reset   (reset),
            .i_clear (flush),
            .i_load  (w_skid_load),
            .i_drop  (w_skid_drop),
            .i_ctrl  (in_ctrl),
            .i_data  (in_data),
            .o_valid (w_skid_valid),
            .o_ctrl  (w_skid_ctrl),
            .o_data  (w_skid_data)
        );
    end else begin : g_no_skid
        assign w_skid_valid = 1'b0;
        assign w_skid_ctrl  = '0;
        assign w_skid_data  = '0;
    end

endmodule
